// File: rtl/pe2row_pkg.sv
// Shared types and constants for the PE-to-row-buffer transmit link.
// Holds default geometry, the lane word type, error bit indices and ceil().
package pe2row_pkg;

   localparam int PKG_DATA_WIDTH = 8;
   localparam int PKG_LAST_WH    = 2;
   localparam int PKG_LAST_IW    = 7;
   localparam int PKG_FIFO_DEPTH = 16;

   typedef logic [PKG_LAST_IW-1:0][PKG_DATA_WIDTH-1:0] lane_word_t;

   localparam int ERR_POP_EMPTY    = 0;
   localparam int ERR_PUSH_BLOCKED = 1;

   // Integer ceiling division, same rounding as HOUT/HINT/LAST_N_UP.
   function automatic int ceil(input int x, input int y);
      return (x + y - 1) / y;
   endfunction

endpackage

// File: rtl/pe2row_lane_fifo.sv
// One synchronous first-word-fall-through lane FIFO with a registered head.
// Ports: clk, rst, push_i, pop_i, din_i, head_o (0 when empty), count_o.
module pe2row_lane_fifo
   import pe2row_pkg::*;
#(
   parameter int WIDTH     = PKG_LAST_IW * PKG_DATA_WIDTH,
   parameter int DEPTH     = PKG_FIFO_DEPTH,
   parameter int CNT_WIDTH = $clog2(PKG_FIFO_DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push_i,
   input  logic                 pop_i,
   input  logic [WIDTH-1:0]     din_i,
   output logic [WIDTH-1:0]     head_o,
   output logic [CNT_WIDTH-1:0] count_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0]     head_q, head_d;
   logic                 pop;

   always_comb begin
      pop      = pop_i & (count_q != '0);
      wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_WIDTH'(push_i) - CNT_WIDTH'(pop);
      // The next head may be the word being written this very cycle.
      head_d   = '0;
      if (count_d != '0) begin
         if (push_i && (rd_ptr_d == wr_ptr_q)) begin
            head_d = din_i;
         end else begin
            head_d = mem_q[rd_ptr_d];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
      end
   end

   assign head_o  = head_q;
   assign count_o = count_q;

endmodule

// File: rtl/pe2row_fifo_array.sv
// Transmit end of the PE-to-row-buffer link: LAST_Wh parallel FWFT lanes.
// Ports: PE push side (pe_out_*), row-buffer side (pe2row_*, dataout, rden),
// per-lane occupancy lane_count and sticky error flags err_sticky.
module pe2row_fifo_array
   import pe2row_pkg::*;
#(
   parameter int DATA_WIDTH = PKG_DATA_WIDTH,
   parameter int LAST_Wh    = PKG_LAST_WH,
   parameter int LAST_Iw    = PKG_LAST_IW,
   parameter int FIFO_DEPTH = PKG_FIFO_DEPTH,
   parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
   input  logic clk,
   input  logic rst,
   input  logic pe_out_valid,
   input  logic [LAST_Wh-1:0][LAST_Iw-1:0][DATA_WIDTH-1:0] pe_out_data,
   output logic pe_out_ready,
   input  logic pe2row_ready,
   output logic pe2row_data_valid,
   output logic [LAST_Wh-1:0][LAST_Iw-1:0][DATA_WIDTH-1:0] fifo_array1_dataout,
   input  logic [LAST_Wh-1:0] pe2row_fifo_array1_rden,
   output logic [LAST_Wh-1:0][CNT_WIDTH-1:0] lane_count,
   output logic [1:0] err_sticky
);

   localparam int WORD_W = LAST_Iw * DATA_WIDTH;

   logic [LAST_Wh-1:0] not_full;
   logic [LAST_Wh-1:0] not_empty;
   logic               push;
   logic [1:0]         err_q, err_d;

   always_comb begin
      not_full  = '0;
      not_empty = '0;
      for (int w = 0; w < LAST_Wh; w++) begin
         not_full[w]  = lane_count[w] < CNT_WIDTH'(FIFO_DEPTH);
         not_empty[w] = lane_count[w] != '0;
      end
   end

   // Ready comes from registered counts only, so a pop from a full lane
   // frees space for a push one cycle later.
   assign pe_out_ready      = ~rst & (&not_full);
   assign push              = pe_out_valid & pe_out_ready;
   assign pe2row_data_valid = pe2row_ready & (&not_empty);

   always_comb begin
      err_d = err_q;
      if (|(pe2row_fifo_array1_rden & ~not_empty)) begin
         err_d[ERR_POP_EMPTY] = 1'b1;
      end
      if (pe_out_valid & ~pe_out_ready) begin
         err_d[ERR_PUSH_BLOCKED] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= '0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_sticky = err_q;

   for (genvar w = 0; w < LAST_Wh; w++) begin : g_lane
      pe2row_lane_fifo #(
         .WIDTH     (WORD_W),
         .DEPTH     (FIFO_DEPTH),
         .CNT_WIDTH (CNT_WIDTH)
      ) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .push_i  (push),
         .pop_i   (pe2row_fifo_array1_rden[w]),
         .din_i   (pe_out_data[w]),
         .head_o  (fifo_array1_dataout[w]),
         .count_o (lane_count[w])
      );
   end

endmodule

// File: doc/pe2row_fifo_array.md
# pe2row_fifo_array

Transmit end of the PE-to-row-buffer link. It accepts completed output rows from the PE array, buffers them in LAST_Wh parallel first-word-fall-through lanes, and presents them to the row buffer through the fifo_array1 / pe2row handshake. It sits between the PE accumulator output and the row buffer of the next layer.

## Interface
- DATA_WIDTH, 8, element width
- LAST_Wh, 2, lane count (PE rows produced per cycle)
- LAST_Iw, 7, elements per lane word
- FIFO_DEPTH, 16, words per lane; power of two, ≥2
- CNT_WIDTH, $clog2(FIFO_DEPTH)+1, occupancy counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- pe_out_valid  in  1  PE offers one word on every lane
- pe_out_data  in  [LAST_Wh-1:0][LAST_Iw-1:0][DATA_WIDTH-1:0]  PE row words
- pe_out_ready  out  1  all lanes can accept a word
- pe2row_ready  in  1  row buffer permits transmission
- pe2row_data_valid  out  1  every lane head is valid and transmission is permitted
- fifo_array1_dataout  out  [LAST_Wh-1:0][LAST_Iw-1:0][DATA_WIDTH-1:0]  lane heads
- pe2row_fifo_array1_rden  in  [LAST_Wh-1:0]  per-lane pop
- lane_count  out  [LAST_Wh-1:0][CNT_WIDTH-1:0]  per-lane occupancy
- err_sticky  out  2  bit0 pop on empty lane, bit1 push while not ready

## Operation
- Push: the PE transfer is pe_out_valid & pe_out_ready. It writes pe_out_data[w] into lane w for all w in the same cycle.
- pe_out_ready = AND over lanes of (count_w < FIFO_DEPTH), evaluated from registered counts.
- pe2row_data_valid = pe2row_ready & AND over lanes of (count_w != 0). It is combinational from pe2row_ready.
- Pop: rden[w] pops lane w whenever count_w != 0, independent of the other lanes and of pe2row_data_valid. The row buffer may drain lanes at different rates.
- Empty-lane pop: ignored, with no pointer or count change. Sets err_sticky[0].
- pe_out_valid while pe_out_ready=0: no write. Sets err_sticky[1].
- err_sticky is cleared only by rst.
- Per lane, push and pop in the same cycle: count unchanged, both pointers advance.
- Pop from a full lane in the same cycle as a blocked push: the push stays blocked because ready is registered. The word is written the next cycle.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. The count saturates at neither end; overflow and underflow are prevented by the rules above.
- There is no state machine beyond per-lane pointers and counts. Lane order is preserved: word k of lane w leaves as the k-th pop of lane w.

## Timing
- Reset values (synchronous; one rst cycle is sufficient):
  - pointers and counts = 0
  - pe_out_ready = 1 after reset, 0 while rst is high
  - pe2row_data_valid = 0
  - fifo_array1_dataout = 0
  - lane_count = 0
  - err_sticky = 0
- Reset mid-transfer discards all buffered words. Stored data RAM contents are don't-care.
- Push at edge t makes the head visible on fifo_array1_dataout and lane_count at t+1 if the lane was empty (FWFT latency 1).
- After a pop at edge t, the next head is visible at t+1. Heads of empty lanes read 0.
- Sustained throughput is one word per lane per cycle with simultaneous push and pop.
- pe_out_ready deasserts the cycle after a lane reaches FIFO_DEPTH. It reasserts the cycle after that lane's count drops below FIFO_DEPTH.

## Structure
- Shared package pe2row_pkg holds:
  - typedef lane_word_t = logic [LAST_Iw-1:0][DATA_WIDTH-1:0]
  - function ceil(x, y), the same rounding used for HOUT/HINT/LAST_N_UP
  - err bit index constants
- Sub-module pe2row_lane_fifo: one synchronous FWFT FIFO with a registered head. It is instantiated LAST_Wh times under generate. The top holds the ready/valid reduction and the sticky error logic.

## Test plan
- Reset, then push one word (lane0 = 0x01..0x07, lane1 = 0x11..0x17) with pe2row_ready=1:
  - valid rises exactly 1 cycle later
  - dataout matches
  - lane_count = {1,1}
- Push 16 words, then assert pe_out_valid again:
  - pe_out_ready = 0
  - 17th word not stored; err_sticky = 2'b10
  - popping both lanes returns words 0..15 in order
- Hold pe2row_ready=0 with both lanes non-empty:
  - pe2row_data_valid = 0
  - raising pe2row_ready gives valid=1 in the same cycle
- Pop lane0 only, 3 times, after 3 pushes:
  - lane_count = {3,0} (lane1, lane0)
  - valid = 0
  - rden[0] once more sets err_sticky[0]; lane counts unchanged
- Continuous push+pop on both lanes for 40 cycles with FIFO_DEPTH=16:
  - counts stay constant
  - pointers wrap twice
  - output sequence equals input sequence
- Assert rst with 5 words buffered:
  - next cycle lane_count = 0, valid = 0, dataout = 0, err_sticky = 0
